env_setpoint_ctl: RTL and testbench

Parametrised setpoint-tracking controller, the generalised successor of the per-quantity humidity control FSM. It owns a clamped setpoint register adjusted by push buttons with hold-to-auto-repeat. It compares a sampled measurement against that setpoint with a hysteresis band, drives one of two actuator enables, and latches a fault when an actuator runs too long without reaching target. One instance serves each controlled quantity (temperature, humidity) in the environment-control subsystem on the APB clock domain.

---
 rtl/env_ctl_pkg.sv | 19 +
 rtl/env_setpoint_ctl_if.sv | 34 +++
 rtl/pb_step_gen.sv | 58 +++++
 rtl/env_setpoint_ctl.sv | 123 ++++++++++++
 tb/tb_env_setpoint_ctl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/env_ctl_pkg.sv
// Shared types for the setpoint-tracking controller.
// ctl_state_t FSM encoding and counter width helper.
package env_ctl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RAISE = 2'b01,
    LOWER = 2'b10,
    FAULT = 2'b11
  } ctl_state_t;

  // Bits needed to hold 0..n, never less than 1.
  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/env_setpoint_ctl_if.sv
// Button/measurement inputs and control outputs
// master drives buttons/meas/fault_clr, slave drives results.
interface env_setpoint_ctl_if
  import env_ctl_pkg::*;
#(
  parameter int W = 8
);

  logic         inc_pb;
  logic         dec_pb;
  logic [W-1:0] meas;
  logic         meas_valid;
  logic         fault_clr;
  logic [W-1:0] setpoint;
  logic         raise_en;
  logic         lower_en;
  logic         fault;
  ctl_state_t   state;

  modport master (
    output inc_pb, dec_pb, meas,
    output meas_valid, fault_clr,
    input  setpoint, raise_en,
    input  lower_en, fault, state
  );

  modport slave (
    input  inc_pb, dec_pb, meas,
    input  meas_valid, fault_clr,
    output setpoint, raise_en,
    output lower_en, fault, state
  );

endinterface

// File: rtl/pb_step_gen.sv
// Push-button step generator: edge step, then hold/auto-repeat.
// Ports: clk, rst_n, pb (level in), step (comb pulse out).
module pb_step_gen
  import env_ctl_pkg::*;
#(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb,
  output logic step
);

  localparam int MAXC =
    (HOLD_CYCLES > REPEAT_CYCLES) ?
    HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW = cnt_w(MAXC);

  logic          pb_q;
  logic          rep_q;
  logic [CW-1:0] cnt_q;
  logic          rise;
  logic          held;
  logic          due;

  assign rise = pb & ~pb_q;
  // cnt_q==0 while held means the press predates reset:
  // stay inert until a genuine release/press.
  assign held = pb & pb_q & (cnt_q != '0);
  assign due  = held & (rep_q ?
    (cnt_q == CW'(REPEAT_CYCLES)) :
    (cnt_q == CW'(HOLD_CYCLES)));
  assign step = rise | due;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pb_q  <= 1'b1;
      rep_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      pb_q <= pb;
      if (rise) begin
        cnt_q <= CW'(1);
        rep_q <= 1'b0;
      end else if (due) begin
        cnt_q <= CW'(1);
        rep_q <= 1'b1;
      end else if (held) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (!pb) begin
        cnt_q <= '0;
        rep_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/env_setpoint_ctl.sv
// Setpoint register, hysteresis FSM and dwell-timeout fault.
// Ports: pclk, presetn, bus (env_setpoint_ctl_if.slave).
module env_setpoint_ctl
  import env_ctl_pkg::*;
#(
  parameter int W              = 8,
  parameter int SP_MIN         = 0,
  parameter int SP_MAX         = 2**W - 1,
  parameter int SP_DEFAULT     = 2**(W-1),
  parameter int HYST           = 2,
  parameter int HOLD_CYCLES    = 50_000_000,
  parameter int REPEAT_CYCLES  = 10_000_000,
  parameter int TIMEOUT_CYCLES = 600_000_000
) (
  input logic               pclk,
  input logic               presetn,
  env_setpoint_ctl_if.slave bus
);

  localparam int DW = cnt_w(TIMEOUT_CYCLES);

  logic          step_inc;
  logic          step_dec;
  logic [W-1:0]  sp_q;
  logic [W-1:0]  meas_q;
  logic [W:0]    m_ext;
  logic [W:0]    lo;
  logic [W:0]    hi;
  logic          below;
  logic          above;
  logic          tmo;
  logic [DW-1:0] dwell_q;
  ctl_state_t    st_q;
  ctl_state_t    st_d;

  pb_step_gen #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_inc (
    .clk   (pclk),
    .rst_n (presetn),
    .pb    (bus.inc_pb),
    .step  (step_inc)
  );

  pb_step_gen #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_dec (
    .clk   (pclk),
    .rst_n (presetn),
    .pb    (bus.dec_pb),
    .step  (step_dec)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      sp_q   <= W'(SP_DEFAULT);
      meas_q <= W'(SP_DEFAULT);
    end else begin
      if (step_inc && !step_dec &&
          sp_q < W'(SP_MAX))
        sp_q <= sp_q + W'(1);
      else if (step_dec && !step_inc &&
               sp_q > W'(SP_MIN))
        sp_q <= sp_q - W'(1);
      if (bus.meas_valid)
        meas_q <= bus.meas;
    end
  end

  // One extra bit: lo[W] set means sp<HYST, so
  // nothing can be below; hi never overflows W+1.
  assign m_ext = {1'b0, meas_q};
  assign lo    = {1'b0, sp_q} - (W+1)'(HYST);
  assign hi    = {1'b0, sp_q} + (W+1)'(HYST);
  assign below = !lo[W] && (m_ext < lo);
  assign above = m_ext > hi;
  assign tmo   = dwell_q == DW'(TIMEOUT_CYCLES - 1);

  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE: begin
        if (below)      st_d = RAISE;
        else if (above) st_d = LOWER;
      end
      RAISE: begin
        if (tmo)                 st_d = FAULT;
        else if (meas_q >= sp_q) st_d = IDLE;
      end
      LOWER: begin
        if (tmo)                 st_d = FAULT;
        else if (meas_q <= sp_q) st_d = IDLE;
      end
      FAULT: begin
        if (bus.fault_clr) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      st_q    <= IDLE;
      dwell_q <= '0;
    end else begin
      st_q <= st_d;
      if (st_d != st_q || st_q == IDLE ||
          st_q == FAULT)
        dwell_q <= '0;
      else
        dwell_q <= dwell_q + DW'(1);
    end
  end

  assign bus.setpoint = sp_q;
  assign bus.state    = st_q;
  assign bus.raise_en = st_q == RAISE;
  assign bus.lower_en = st_q == LOWER;
  assign bus.fault    = st_q == FAULT;

endmodule

// File: tb/tb_env_setpoint_ctl.sv
// Self-checking bench for env_setpoint_ctl.
// Table vectors plus hand sequences through a scoreboard queue.
module tb_env_setpoint_ctl;
  import env_ctl_pkg::*;

  typedef struct {
    logic       inc;
    logic       dec;
    logic       mv;
    logic [7:0] m;
    logic       clr;
    logic [7:0] sp;
    ctl_state_t st;
  } vec_t;

  typedef struct {
    logic [7:0] sp;
    ctl_state_t st;
    logic       chk;
    string      nm;
  } exp_t;

  logic   pclk = 1'b0;
  logic   presetn = 1'b0;
  int     n_vec = 0;
  int     n_err = 0;
  exp_t   sb[$];
  vec_t   tbl[$];

  env_setpoint_ctl_if #(.W(8)) bus ();

  env_setpoint_ctl #(
    .W              (8),
    .SP_MIN         (10),
    .SP_MAX         (60),
    .SP_DEFAULT     (50),
    .HYST           (2),
    .HOLD_CYCLES    (8),
    .REPEAT_CYCLES  (3),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus.slave)
  );

  always #5 pclk = ~pclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time limit hit");
    $fatal(1, "watchdog");
  end

  // Steps fired by held cycle j (0 = press edge).
  function automatic int ns(input int j);
    return (j < 8) ? 1 : 2 + (j - 8) / 3;
  endfunction

  function automatic vec_t v(
    input logic inc, dec, mv,
    input logic [7:0] m,
    input logic clr,
    input logic [7:0] sp,
    input ctl_state_t st);
    vec_t r;
    r.inc = inc; r.dec = dec; r.mv = mv;
    r.m = m; r.clr = clr; r.sp = sp; r.st = st;
    return r;
  endfunction

  task automatic push(input logic [7:0] sp,
                      input ctl_state_t st,
                      input logic chk,
                      input string nm);
    exp_t e;
    e.sp = sp; e.st = st; e.chk = chk; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    logic bad;
    e = sb.pop_front();
    n_vec++;
    bad = bus.setpoint !== e.sp;
    if (e.chk)
      bad = bad || bus.state !== e.st ||
        bus.raise_en !== (e.st == RAISE) ||
        bus.lower_en !== (e.st == LOWER) ||
        bus.fault !== (e.st == FAULT);
    if (bad) begin
      n_err++;
      $display("FAIL %s: got sp=%0d st=%0d rlf=%b%b%b want sp=%0d st=%0d",
        e.nm, bus.setpoint, bus.state, bus.raise_en,
        bus.lower_en, bus.fault, e.sp, e.st);
    end
  endtask

  task automatic cyc(input logic inc, dec, mv,
                     input logic [7:0] m,
                     input logic clr,
                     input int sp,
                     input ctl_state_t st,
                     input logic chk,
                     input string nm);
    @(negedge pclk);
    bus.inc_pb = inc;
    bus.dec_pb = dec;
    bus.meas_valid = mv;
    bus.meas = m;
    bus.fault_clr = clr;
    push(8'(sp), st, chk, nm);
    @(posedge pclk);
    #1;
    pop_cmp();
  endtask

  task automatic do_reset();
    @(negedge pclk);
    bus.inc_pb = 0;
    bus.dec_pb = 0;
    bus.meas_valid = 0;
    bus.meas = 0;
    bus.fault_clr = 0;
    presetn = 0;
    #1;
    push(8'd50, IDLE, 1'b1, "reset");
    pop_cmp();
    @(negedge pclk);
    presetn = 1;
  endtask

  initial begin
    bus.inc_pb = 0;
    bus.dec_pb = 0;
    bus.meas_valid = 0;
    bus.meas = 0;
    bus.fault_clr = 0;

    tbl.push_back(v(0,0,1,47,0,50,IDLE));
    tbl.push_back(v(0,0,0,47,0,50,RAISE));
    tbl.push_back(v(0,0,1,50,0,50,RAISE));
    tbl.push_back(v(0,0,0,50,0,50,IDLE));
    tbl.push_back(v(0,0,1,53,0,50,IDLE));
    tbl.push_back(v(0,0,0,53,0,50,LOWER));
    tbl.push_back(v(0,0,1,50,0,50,LOWER));
    tbl.push_back(v(0,0,0,50,0,50,IDLE));
    tbl.push_back(v(0,0,1,48,0,50,IDLE));
    tbl.push_back(v(0,0,0,48,0,50,IDLE));
    tbl.push_back(v(0,0,1,52,0,50,IDLE));
    tbl.push_back(v(0,0,0,52,0,50,IDLE));
    tbl.push_back(v(0,0,0,52,1,50,IDLE));

    repeat (2) @(posedge pclk);
    do_reset();

    foreach (tbl[i])
      cyc(tbl[i].inc, tbl[i].dec, tbl[i].mv,
          tbl[i].m, tbl[i].clr, tbl[i].sp,
          tbl[i].st, 1'b1, "hyst_tbl");

    // meas_q=52: IDLE until sp reaches 55.
    for (int j = 0; j < 20; j++)
      cyc(1,0,0,52,0, 50 + ns(j),
          (j >= 18) ? RAISE : IDLE, 1'b1, "inc_hold");
    cyc(0,0,0,52,0,55,RAISE,1'b1,"inc_rel");
    cyc(0,1,0,52,0,54,RAISE,1'b1,"dec_pulse");
    cyc(0,0,1,54,0,54,RAISE,1'b1,"meas54");
    cyc(0,0,0,54,0,54,IDLE,1'b1,"raise_exit");

    do_reset();
    for (int j = 0; j < 30; j++)
      cyc(1,0,0,0,0, 50 + ns(j), IDLE, 1'b0,
          "to59");
    cyc(0,0,0,0,0,59,IDLE,1'b0,"rel59");
    for (int j = 0; j < 30; j++)
      cyc(1,0,0,0,0, (59 + ns(j) > 60) ? 60 :
          59 + ns(j), IDLE, 1'b0, "sat_hi");
    cyc(0,0,0,0,0,60,IDLE,1'b0,"rel60");
    for (int j = 0; j < 170; j++)
      cyc(0,1,0,0,0, (60 - ns(j) < 10) ? 10 :
          60 - ns(j), IDLE, 1'b0, "sat_lo");
    cyc(0,0,0,0,0,10,IDLE,1'b0,"rel10");
    cyc(0,1,0,0,0,10,IDLE,1'b0,"dec_at_min");
    cyc(0,0,0,0,0,10,IDLE,1'b0,"rel_min");
    cyc(1,1,0,0,0,10,IDLE,1'b0,"both_pb");
    cyc(0,0,0,0,0,10,IDLE,1'b0,"both_rel");
    cyc(1,0,0,0,0,11,IDLE,1'b0,"inc_after");

    do_reset();
    cyc(0,0,1,40,0,50,IDLE,1'b1,"to_meas");
    cyc(0,0,0,40,0,50,RAISE,1'b1,"to_raise");
    for (int j = 1; j < 20; j++)
      cyc(0,0,0,40, (j == 5), 50, RAISE, 1'b1,
          "to_dwell");
    cyc(0,0,0,40,0,50,FAULT,1'b1,"to_fault");
    cyc(1,0,0,40,0,51,FAULT,1'b1,"inc_fault");
    cyc(0,0,0,40,0,51,FAULT,1'b1,"fault_hold");
    cyc(0,0,0,40,1,51,IDLE,1'b1,"fault_clr");
    cyc(0,0,0,40,0,51,RAISE,1'b1,"re_raise");

    do_reset();
    cyc(0,0,1,47,0,50,IDLE,1'b1,"f_meas");
    cyc(0,0,0,47,0,50,RAISE,1'b1,"f_raise");
    cyc(1,0,0,47,0,51,RAISE,1'b1,"f_inc");
    cyc(0,0,0,47,0,51,RAISE,1'b1,"f_rel");
    cyc(0,0,1,50,0,51,RAISE,1'b1,"f_m50");
    cyc(0,0,0,50,0,51,RAISE,1'b1,"f_stay");
    cyc(0,1,0,50,0,50,RAISE,1'b1,"f_dec");
    cyc(0,0,0,50,0,50,IDLE,1'b1,"f_exit");

    do_reset();
    cyc(0,0,1,47,0,50,IDLE,1'b1,"x_meas");
    cyc(0,0,0,47,0,50,RAISE,1'b1,"x_raise");
    for (int j = 1; j < 19; j++)
      cyc(0,0,0,47,0,50,RAISE,1'b1,"x_dwell");
    cyc(0,0,1,50,0,50,RAISE,1'b1,"x_m50");
    cyc(0,0,0,50,0,50,FAULT,1'b1,"x_both");

    do_reset();
    cyc(0,0,1,47,0,50,IDLE,1'b1,"g_meas");
    cyc(0,0,0,47,0,50,RAISE,1'b1,"g_raise");
    for (int j = 0; j < 4; j++)
      cyc(1,0,0,47,0,51,RAISE,1'b1,"g_hold");
    @(negedge pclk);
    presetn = 0;
    #1;
    push(8'd50, IDLE, 1'b1, "g_async_rst");
    pop_cmp();
    @(negedge pclk);
    presetn = 1;
    for (int j = 0; j < 15; j++)
      cyc(1,0,0,47,0,50,IDLE,1'b1,"g_held_rst");
    cyc(0,0,0,47,0,50,IDLE,1'b1,"g_rel");
    cyc(1,0,0,47,0,51,IDLE,1'b1,"g_repress");
    cyc(0,0,0,47,0,51,IDLE,1'b1,"g_idle");

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
